// File: rtl/multi_ultrasonic_ranger.sv
// multi_ultrasonic_ranger: round-robin HC-SR04 front end.
// Per-channel cm distance with echo timeout, saturation and near flag.
module multi_ultrasonic_ranger #(
  parameter int NUM_CH     = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int DIST_W     = 10,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [DIST_W-1:0]        threshold_cm,
  input  logic [NUM_CH-1:0]        echo,
  output logic [NUM_CH-1:0]        trig,
  output logic [NUM_CH*DIST_W-1:0] dist_flat,
  output logic [NUM_CH-1:0]        near,
  output logic                     meas_valid,
  output logic [CH_W-1:0]          meas_ch,
  output logic                     meas_timeout
);
  localparam int US_CYC   = CLK_HZ / 1_000_000;
  localparam int CM_CYC   = 58 * US_CYC;
  localparam int TRIG_CYC = TRIG_US * US_CYC;
  localparam int TO_CYC   = TIMEOUT_US * US_CYC;
  localparam int PER_CYC  = PERIOD_US * US_CYC;
  localparam int CNT_MAX  = (TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int PER_W    = $clog2(PER_CYC + 1);
  localparam int PRE_W    = $clog2(CM_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [PRE_W-1:0]    pre_q, pre_d, pre_nx;
  logic [DIST_W-1:0]   cm_q, cm_d, cm_nx;
  logic [NUM_CH-1:0]   s1_q, s2_q;
  logic [DIST_W-1:0]   dist_q [NUM_CH];
  logic [NUM_CH-1:0]   have_q;
  logic                valid_q, to_q;
  logic                commit, res_to;
  logic [DIST_W-1:0]   res;
  logic                echo_s;

  assign echo_s       = s2_q[ch_q];
  assign meas_valid   = valid_q;
  assign meas_timeout = to_q;
  assign meas_ch      = ch_q;

  // Two-flop synchroniser for the asynchronous echo pins.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= echo;
      s2_q <= s1_q;
    end
  end

  // One echo-high cycle: prescaler wraps at CM_CYC, cm saturates.
  always_comb begin
    pre_nx = pre_q + 1'b1;
    cm_nx  = cm_q;
    if (pre_q == PRE_W'(CM_CYC - 1)) begin
      pre_nx = '0;
      if (cm_q != '1) cm_nx = cm_q + 1'b1;
    end
  end

  // Sequencer next state, counters and result commit.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    cm_d    = cm_q;
    per_d   = (per_q == PER_W'(PER_CYC)) ? per_q : per_q + 1'b1;
    commit  = 1'b0;
    res     = '0;
    res_to  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_TRIG;
          per_d   = '0;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          pre_d   = '0;
          cm_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (echo_s) begin
          state_d = S_MEAS;
          cnt_d   = CNT_W'(1);
          pre_d   = pre_nx;
          cm_d    = cm_nx;
        end else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
          state_d = S_HOLD;
          commit  = 1'b1;
          res     = '1;
          res_to  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEAS: begin
        if (!echo_s) begin
          state_d = S_HOLD;
          commit  = 1'b1;
          res     = cm_q;
        end else if (cnt_q == CNT_W'(TO_CYC)) begin
          state_d = S_HOLD;
          commit  = 1'b1;
          res     = '1;
          res_to  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          pre_d = pre_nx;
          cm_d  = cm_nx;
        end
      end
      S_HOLD: begin
        if (per_q >= PER_W'(PER_CYC - 1)) begin
          ch_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          if (enable) begin
            state_d = S_TRIG;
            per_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      pre_q   <= '0;
      cm_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      cm_q    <= cm_d;
    end
  end

  // Per-channel stored distance and the completion pulse.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) dist_q[k] <= '0;
      have_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      valid_q <= commit;
      to_q    <= commit & res_to;
      if (commit) begin
        dist_q[ch_q] <= res;
        have_q[ch_q] <= 1'b1;
      end
    end
  end

  // Trigger follows the registered state so reset drops it at once.
  always_comb begin
    trig = '0;
    if (state_q == S_TRIG) trig[ch_q] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign dist_flat[k*DIST_W +: DIST_W] = dist_q[k];
    assign near[k] = have_q[k] && (dist_q[k] < threshold_cm);
  end

endmodule

// File: tb/tb_multi_ultrasonic_ranger.sv
// tb_multi_ultrasonic_ranger: directed bench with a per-cycle model
// of the measurement schedule, for a 10-bit and a 4-bit instance.
module tb_multi_ultrasonic_ranger;
  localparam int TRIG = 10;
  localparam int TOUT = 3000;
  localparam int PER  = 6000;
  localparam int CM   = 58;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [9:0]  thr = 10'd20;
  logic [3:0]  thr4 = 4'd8;
  logic [3:0]  echo = '0;
  logic [3:0]  trig_a, trig_b, near_a, near_b;
  logic [39:0] df_a;
  logic [15:0] df_b;
  logic        mv_a, mv_b, mt_a, mt_b;
  logic [1:0]  mc_a, mc_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int trig0_cnt = 0;
  int rise_t[$];
  int rise_ch[$];

  typedef struct {
    int ch;
    int t;
    int v;
    int cm;
    bit to;
  } rec_t;
  rec_t recs[$];

  multi_ultrasonic_ranger #(
    .NUM_CH(4), .CLK_HZ(1_000_000), .TRIG_US(TRIG),
    .TIMEOUT_US(TOUT), .PERIOD_US(PER), .DIST_W(10)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .enable(en),
    .threshold_cm(thr), .echo(echo), .trig(trig_a),
    .dist_flat(df_a), .near(near_a), .meas_valid(mv_a),
    .meas_ch(mc_a), .meas_timeout(mt_a)
  );

  multi_ultrasonic_ranger #(
    .NUM_CH(4), .CLK_HZ(1_000_000), .TRIG_US(TRIG),
    .TIMEOUT_US(TOUT), .PERIOD_US(PER), .DIST_W(4)
  ) dut4 (
    .CLOCK_50(clk), .reset_n(rst_n), .enable(en),
    .threshold_cm(thr4), .echo(echo), .trig(trig_b),
    .dist_flat(df_b), .near(near_b), .meas_valid(mv_b),
    .meas_ch(mc_b), .meas_timeout(mt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic to_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Plan one measurement, register its expected record, drive echo.
  // kind 0: echo of n cycles, 1: no echo, 2: stuck high.
  task automatic meas(input int ch, input int kind, input int n,
                      input int t, input bit drop, output int v);
    rec_t r;
    int w, c;
    w = t + TRIG;
    c = 0;
    v = 0;
    r.ch = ch; r.t = t; r.cm = 0; r.to = 1'b0;
    if (kind == 0) begin
      c = w + 98;
      v = c + n + 3;
      r.cm = n / CM;
    end else if (kind == 1) begin
      v = w + TOUT;
      r.to = 1'b1;
    end else begin
      c = t + 2;
      v = w + TOUT + 1;
      r.to = 1'b1;
    end
    r.v = v;
    recs.push_back(r);
    if (kind == 0) begin
      to_neg(c);
      echo[ch] = 1'b1;
      if (drop) begin
        to_neg(c + n / 2);
        en = 1'b0;
      end
      to_neg(c + n);
      echo[ch] = 1'b0;
    end else if (kind == 2) begin
      to_neg(c);
      echo[ch] = 1'b1;
      to_neg(v);
      echo[ch] = 1'b0;
    end
    to_neg(v);
  endtask

  // Per-cycle compare against the schedule model.
  initial begin : cmp
    logic [3:0]  et, pt, na, nb;
    logic [39:0] ea;
    logic [15:0] eb;
    bit          ev, eto;
    int          ech, da, db;
    int          cmv[4];
    bit          tov[4], hv[4];
    pt = '0;
    forever begin
      @(posedge clk);
      #1;
      et = '0; ev = 1'b0; eto = 1'b0; ech = 0;
      for (int c = 0; c < 4; c++) begin
        cmv[c] = 0; tov[c] = 1'b0; hv[c] = 1'b0;
      end
      foreach (recs[i]) begin
        if (cyc >= recs[i].t && cyc < recs[i].t + TRIG)
          et[recs[i].ch] = 1'b1;
        if (cyc == recs[i].v) begin
          ev = 1'b1; ech = recs[i].ch; eto = recs[i].to;
        end
        if (cyc >= recs[i].v) begin
          hv[recs[i].ch] = 1'b1;
          cmv[recs[i].ch] = recs[i].cm;
          tov[recs[i].ch] = recs[i].to;
        end
      end
      ea = '0; eb = '0; na = '0; nb = '0;
      for (int c = 0; c < 4; c++) begin
        da = tov[c] ? 1023 : ((cmv[c] > 1023) ? 1023 : cmv[c]);
        db = tov[c] ? 15 : ((cmv[c] > 15) ? 15 : cmv[c]);
        ea[c*10 +: 10] = 10'(da);
        eb[c*4 +: 4] = 4'(db);
        na[c] = hv[c] && (da < int'(thr));
        nb[c] = hv[c] && (db < int'(thr4));
      end
      chk("trig_a", trig_a, et);
      chk("trig_b", trig_b, et);
      chk("valid_a", mv_a, ev);
      chk("valid_b", mv_b, ev);
      chk("dist_a", df_a, ea);
      chk("dist_b", df_b, eb);
      chk("near_a", near_a, na);
      chk("near_b", near_b, nb);
      if (ev) begin
        chk("ch_a", mc_a, ech);
        chk("ch_b", mc_b, ech);
        chk("to_a", mt_a, eto);
        chk("to_b", mt_b, eto);
      end
      if (mv_a) vcnt++;
      if (trig_a[0]) trig0_cnt++;
      if (trig_a != 0 && pt == 0) begin
        rise_t.push_back(cyc);
        for (int b = 0; b < 4; b++)
          if (trig_a[b]) rise_ch.push_back(b);
      end
      pt = trig_a;
    end
  end

  initial begin : wdog
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int pch[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
    int pkind[8] = '{0, 0, 0, 0, 0, 2, 1, 0};
    int pn[8]    = '{580, 290, 1160, 57, 116, 0, 0, 580};
    int t, v, t7, x;
    rec_t r;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    to_neg(cyc + 1000);
    chk("idle_valid_cnt", vcnt, 0);
    chk("idle_dist", df_a, 0);
    chk("idle_near", near_a, 0);
    chk("idle_trig", trig_a, 0);
    en = 1'b1;
    t = cyc + 1;
    t7 = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) t7 = t;
      meas(pch[k], pkind[k], pn[k], t, k == 7, v);
      case (k)
        0: begin
          chk("m0_dist0", df_a[9:0], 10);
          chk("m0_near0", near_a[0], 1);
          chk("m0_ch", mc_a, 0);
          chk("m0_to", mt_a, 0);
          chk("m0_valid", mv_a, 1);
          chk("m0_trig_len", trig0_cnt, 10);
        end
        2: begin
          chk("m2_dist2", df_a[29:20], 20);
          chk("m2_sat4", df_b[11:8], 15);
          chk("m2_to4", mt_b, 0);
        end
        3: chk("m3_dist3", df_a[39:30], 0);
        4: begin
          chk("m4_dist0", df_a[9:0], 2);
          chk("m4_dist1", df_a[19:10], 5);
          chk("rise_cnt", rise_t.size(), 5);
          if (rise_t.size() >= 5) begin
            for (int i = 0; i < 4; i++)
              chk("rise_gap", rise_t[i+1] - rise_t[i], PER);
            for (int i = 0; i < 5; i++)
              chk("rise_ch", rise_ch[i], i % 4);
          end
          thr = 10'd3;
          #1;
          chk("thr_live_near", near_a, 4'b1001);
        end
        5: begin
          chk("m5_dist1", df_a[19:10], 1023);
          chk("m5_to", mt_a, 1);
          chk("m5_dist1_4", df_b[7:4], 15);
        end
        6: begin
          chk("m6_ch", mc_a, 2);
          chk("m6_to", mt_a, 1);
          chk("m6_dist2", df_a[29:20], 1023);
          chk("m6_near2", near_a[2], 0);
        end
        7: begin
          chk("m7_ch", mc_a, 3);
          chk("m7_to", mt_a, 0);
          chk("m7_dist3", df_a[39:30], 10);
        end
        default: ;
      endcase
      t = (t + PER > v + 1) ? t + PER : v + 1;
    end
    to_neg(t7 + PER + 200);
    chk("idle_after_drop", trig_a, 0);
    x = cyc;
    en = 1'b1;
    r.ch = 0; r.t = x + 1; r.v = 1 << 30; r.cm = 0; r.to = 1'b0;
    recs.push_back(r);
    to_neg(x + 5);
    chk("reen_trig0", trig_a, 4'b0001);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en = 1'b0;
    recs.delete();
    #1;
    chk("rst_trig_a", trig_a, 0);
    chk("rst_trig_b", trig_b, 0);
    chk("rst_dist", df_a, 0);
    chk("rst_near", near_a, 0);
    chk("rst_valid", mv_a, 0);
    chk("rst_ch", mc_a, 0);
    chk("rst_to", mt_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
